// File: rtl/mem_burst_if.sv
// Request, write-data and read-data channels of the line-burst memory.
// All three use valid/ready: a beat transfers on a rising edge where both are high.
interface mem_burst_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;
  logic              wr_done;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, wdata_valid, wdata, rdata_ready,
    input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, wdata_valid, wdata, rdata_ready,
    output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, busy
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Line-burst main memory: one outstanding read or write of BURST_LEN words,
// critical word first with wrap inside the line, fixed access latency.
module mem_burst_ctrl #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 10,
  parameter int                BURST_LEN = 4,
  parameter int                LATENCY   = 3,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_burst_if.slave  bus,
  output logic [2:0]  fsm_state
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);

  if (BURST_LEN < 1 || (BURST_LEN & (BURST_LEN - 1)) != 0 || BURST_LEN > DEPTH) begin : g_bad_burst
    $fatal(1, "mem_burst_ctrl: BURST_LEN must be a power of 2 in [1, 2^ADDR_W]");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $fatal(1, "mem_burst_ctrl: LATENCY must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] next_beat;
  logic [CNT_W-1:0]  cnt;

  // Contents are preset once at time 0; reset deliberately leaves them alone.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [BEAT_W-1:0] b);
    return (a & ~LINE_MASK) | ((a + ADDR_W'(b)) & LINE_MASK);
  endfunction

  assign next_beat = beat + 1'b1;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst_n && state == WR_DATA && bus.wdata_valid)
      mem[beat_addr(addr_q, beat)] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      addr_q          <= '0;
      beat            <= '0;
      cnt             <= '0;
      bus.req_ready   <= 1'b0;
      bus.wdata_ready <= 1'b0;
      bus.rdata_valid <= 1'b0;
      bus.rdata       <= '0;
      bus.rdata_last  <= 1'b0;
      bus.wr_done     <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.wr_done <= 1'b0;
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            addr_q        <= bus.req_addr;
            beat          <= '0;
            cnt           <= CNT_LOAD;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (bus.req_we) begin
              bus.wdata_ready <= 1'b1;
              state           <= WR_DATA;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            bus.rdata       <= mem[beat_addr(addr_q, beat)];
            bus.rdata_valid <= 1'b1;
            bus.rdata_last  <= (beat == LAST_BEAT);
            state           <= RD_BURST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_BURST: begin
          // rdata_valid is always high here, so rdata_ready alone marks a handshake.
          if (bus.rdata_ready) begin
            if (beat == LAST_BEAT) begin
              bus.rdata_valid <= 1'b0;
              bus.rdata_last  <= 1'b0;
              bus.req_ready   <= 1'b1;
              bus.busy        <= 1'b0;
              state           <= IDLE;
            end else begin
              beat           <= next_beat;
              bus.rdata      <= mem[beat_addr(addr_q, next_beat)];
              bus.rdata_last <= (next_beat == LAST_BEAT);
            end
          end
        end
        WR_DATA: begin
          if (bus.wdata_valid) begin
            if (beat == LAST_BEAT) begin
              bus.wdata_ready <= 1'b0;
              cnt             <= CNT_LOAD;
              state           <= WR_WAIT;
            end else begin
              beat <= next_beat;
            end
          end
        end
        WR_WAIT: begin
          if (cnt == '0) begin
            bus.wr_done   <= 1'b1;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
